spi_peripheral: RTL

Byte-oriented SPI peripheral (slave) responder, the far end of the link driven by the core's SPI controller. Oversamples SCLK, CS_N and MOSI in the system clock domain, shifts in one received byte per frame and shifts out one transmit byte per frame, MSB first, in any of the four CPOL/CPHA modes. Presents received bytes as a one-cycle valid pulse and accepts transmit bytes through a one-entry valid/ready holding register.

---
 rtl/spi_peripheral_if.sv | 22 ++
 rtl/spi_peripheral.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral_if.sv
// Byte-stream side of the SPI peripheral.
//   tx_data/tx_valid -> peripheral, tx_ready/tx_underrun <- peripheral
//   rx_data/rx_valid <- peripheral
// master: the local user of the peripheral; slave: the peripheral itself.
interface spi_peripheral_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_underrun, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_underrun, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_peripheral.sv
// Byte-oriented SPI peripheral (slave), all four CPOL/CPHA modes, MSB first.
// SCLK/CS_N/MOSI are oversampled in the clk domain.
//   clk, rst        : system clock, asynchronous active-high reset
//   sclk, cs_n, mosi: SPI pins from the controller (asynchronous)
//   miso, miso_oe   : serial data out (0 when deselected) and its output enable
//   cpol, cpha      : mode, latched when selection begins
//   busy            : high while selected (ACTIVE)
//   bus             : tx holding register (valid/ready) and rx byte pulse
module spi_peripheral (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  input  logic cpol,
  input  logic cpha,
  output logic busy,
  spi_peripheral_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state_q, state_d;
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       cpol_l, cpha_l;
  logic [2:0] cnt;
  logic [7:0] rx_shift, tx_shift, hold, rx_data_q;
  logic       hold_full, rx_valid_q, underrun_q;
  logic       lead, trail, enter, do_sample, do_shift, do_load, capture;

  // Two synchronizer flops plus a third for edge detection; the edge strobes
  // are registered so an action lands 4 clk after the pin transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], sclk};
      cs_q      <= {cs_q[1:0], cs_n};
      mosi_q    <= {mosi_q[0], mosi};
      sclk_rise <= sclk_q[1] & ~sclk_q[2];
      sclk_fall <= ~sclk_q[1] & sclk_q[2];
      cs_rise   <= cs_q[1] & ~cs_q[2];
      cs_fall   <= ~cs_q[1] & cs_q[2];
    end
  end

  assign lead    = cpol_l ? sclk_fall : sclk_rise;
  assign trail   = cpol_l ? sclk_rise : sclk_fall;
  assign capture = bus.tx_valid & ~hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The shifting edge reloads instead of shifting when the counter is at 0:
  // for cpha=0 that is the trailing edge after the 8th sample, for cpha=1 the
  // first leading edge of a frame. cpha=0 also loads on entry.
  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    do_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          enter   = 1'b1;
          do_load = ~cpha;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (cpha_l) begin
          do_sample = trail;
          if (lead) begin
            do_load  = (cnt == 3'd0);
            do_shift = (cnt != 3'd0);
          end
        end else begin
          do_sample = lead;
          if (trail) begin
            do_load  = (cnt == 3'd0);
            do_shift = (cnt != 3'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      cnt        <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (enter) begin
        cpol_l   <= cpol;
        cpha_l   <= cpha;
        cnt      <= '0;
        tx_shift <= '0;
      end
      if (do_sample) begin
        rx_shift <= {rx_shift[6:0], mosi_q[1]};
        cnt      <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          rx_data_q  <= {rx_shift[6:0], mosi_q[1]};
          rx_valid_q <= 1'b1;
        end
      end
      // A load only empties a full register and a capture only fills an empty
      // one, so the two never contend for hold_full.
      if (do_load) begin
        if (hold_full) begin
          tx_shift  <= hold;
          hold_full <= 1'b0;
        end else begin
          tx_shift   <= '0;
          underrun_q <= 1'b1;
        end
      end else if (do_shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (capture) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign busy            = (state_q == ACTIVE);
  assign miso_oe         = busy;
  assign miso            = busy & tx_shift[7];
  assign bus.tx_ready    = ~hold_full;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;

endmodule
